// File: rtl/alu_mc.sv
// Multi-cycle ALU with a valid/ready handshake on both sides: single-cycle logic/arith/shift ops
// plus an iterative shift-add unsigned multiplier. A small protocol checker sits alongside.

module alu_mc_checker #(
  parameter int W = 32
) (
  input logic         clk,
  input logic         rst,
  input logic         in_ready,
  input logic         out_valid,
  input logic         out_ready,
  input logic [W-1:0] Result,
  input logic [W-1:0] Result_hi,
  input logic         Overflow,
  input logic         CarryOut,
  input logic         Zero,
  input logic         Illegal
);

  // A stalled result must not move until the consumer takes it.
  a_hold: assert property (@(posedge clk) disable iff (rst)
    (out_valid && !out_ready) |=> (out_valid && $stable(Result) && $stable(Result_hi) &&
                                   $stable({Overflow, CarryOut, Zero, Illegal})));

  a_stall_blocks_issue: assert property (@(posedge clk) disable iff (rst)
    (out_valid && !out_ready) |-> !in_ready);

  a_zero_flag: assert property (@(posedge clk) disable iff (rst)
    out_valid |-> (Zero == (Result == {W{1'b0}})));

  a_illegal_clean: assert property (@(posedge clk) disable iff (rst)
    (out_valid && Illegal) |-> (Result == {W{1'b0}} && Result_hi == {W{1'b0}} &&
                                !Overflow && !CarryOut));

endmodule

module alu_mc #(
  parameter int DATA_WIDTH = 32,
  parameter bit MUL_ENABLE = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] A,
  input  logic [DATA_WIDTH-1:0] B,
  input  logic [3:0]            ALUop,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] Result,
  output logic [DATA_WIDTH-1:0] Result_hi,
  output logic                  Overflow,
  output logic                  CarryOut,
  output logic                  Zero,
  output logic                  Illegal
);

  localparam int W   = DATA_WIDTH;
  localparam int MSB = DATA_WIDTH - 1;
  localparam int SHW = $clog2(DATA_WIDTH);
  localparam logic [SHW-1:0] LAST_STEP = SHW'(DATA_WIDTH - 1);

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_XOR  = 4'b0011;
  localparam logic [3:0] OP_NOR  = 4'b0100;
  localparam logic [3:0] OP_SLTU = 4'b0101;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_SLL  = 4'b1000;
  localparam logic [3:0] OP_SRL  = 4'b1001;
  localparam logic [3:0] OP_SRA  = 4'b1010;
  localparam logic [3:0] OP_MUL  = 4'b1100;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_r;
  logic [2*W-1:0]  prod_r;
  logic [W-1:0]    mcand_r;
  logic [SHW-1:0]  count_r;

  logic            accept_s;
  logic            is_mul_s;
  logic            sub_s;
  logic [W-1:0]    b_eff_s;
  logic [W:0]      addr_s;
  logic            add_ovf_s;
  logic [SHW-1:0]  sh_s;
  logic [W-1:0]    res_s;
  logic            ovf_s;
  logic            cout_s;
  logic            ill_s;
  logic [W:0]      mul_add_s;
  logic [2*W-1:0]  mul_next_s;

  function automatic logic [W:0] add_sub(input logic [W-1:0] a, input logic [W-1:0] b_eff,
                                         input logic cin);
    return {1'b0, a} + {1'b0, b_eff} + {{W{1'b0}}, cin};
  endfunction

  // Two's-complement overflow of a + b_eff: equal operand signs, different result sign.
  function automatic logic add_overflow(input logic a_msb, input logic b_msb, input logic s_msb);
    return (a_msb == b_msb) && (s_msb != a_msb);
  endfunction

  assign in_ready = (state_r == IDLE) | ((state_r == DONE) & out_ready);
  assign accept_s = in_valid & in_ready;
  assign is_mul_s = (ALUop == OP_MUL) & MUL_ENABLE;
  assign sh_s     = B[SHW-1:0];

  // Single-cycle datapath: one shared adder serves ADD, SUB, SLT and SLTU.
  always_comb begin
    sub_s     = (ALUop == OP_SUB) | (ALUop == OP_SLT) | (ALUop == OP_SLTU);
    b_eff_s   = sub_s ? ~B : B;
    addr_s    = add_sub(A, b_eff_s, sub_s);
    add_ovf_s = add_overflow(A[MSB], b_eff_s[MSB], addr_s[MSB]);
    res_s     = {W{1'b0}};
    ovf_s     = 1'b0;
    cout_s    = 1'b0;
    ill_s     = 1'b0;
    case (ALUop)
      OP_AND:  res_s = A & B;
      OP_OR:   res_s = A | B;
      OP_XOR:  res_s = A ^ B;
      OP_NOR:  res_s = ~(A | B);
      OP_ADD, OP_SUB: begin
        res_s  = addr_s[W-1:0];
        ovf_s  = add_ovf_s;
        cout_s = addr_s[W];
      end
      OP_SLT:  res_s = {{(W-1){1'b0}}, addr_s[MSB] ^ add_ovf_s};
      OP_SLTU: res_s = {{(W-1){1'b0}}, ~addr_s[W]};
      OP_SLL:  res_s = A << sh_s;
      OP_SRL:  res_s = A >> sh_s;
      OP_SRA:  res_s = W'($signed(A) >>> sh_s);
      OP_MUL: begin
        if (MUL_ENABLE) begin
          ill_s = 1'b0;
        end else begin
          ill_s = 1'b1;
        end
      end
      default: ill_s = 1'b1;
    endcase
  end

  // One shift-add step: conditionally add the multiplicand into the high half, then shift right.
  always_comb begin
    mul_add_s  = {1'b0, prod_r[2*W-1:W]} + (prod_r[0] ? {1'b0, mcand_r} : {(W+1){1'b0}});
    mul_next_s = {mul_add_s, prod_r[W-1:1]};
  end

  // Control FSM with all result outputs registered here.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= IDLE;
      prod_r    <= {(2*W){1'b0}};
      mcand_r   <= {W{1'b0}};
      count_r   <= {SHW{1'b0}};
      out_valid <= 1'b0;
      Result    <= {W{1'b0}};
      Result_hi <= {W{1'b0}};
      Overflow  <= 1'b0;
      CarryOut  <= 1'b0;
      Zero      <= 1'b0;
      Illegal   <= 1'b0;
    end else if (accept_s) begin
      if (is_mul_s) begin
        state_r   <= MUL;
        prod_r    <= {{W{1'b0}}, B};
        mcand_r   <= A;
        count_r   <= {SHW{1'b0}};
        out_valid <= 1'b0;
        Illegal   <= 1'b0;
      end else begin
        state_r   <= DONE;
        out_valid <= 1'b1;
        Result    <= res_s;
        Result_hi <= {W{1'b0}};
        Overflow  <= ovf_s;
        CarryOut  <= cout_s;
        Zero      <= (res_s == {W{1'b0}});
        Illegal   <= ill_s;
      end
    end else begin
      case (state_r)
        IDLE: state_r <= IDLE;
        MUL: begin
          prod_r  <= mul_next_s;
          count_r <= count_r + SHW'(1);
          if (count_r == LAST_STEP) begin
            state_r   <= DONE;
            out_valid <= 1'b1;
            Result    <= mul_next_s[W-1:0];
            Result_hi <= mul_next_s[2*W-1:W];
            Overflow  <= 1'b0;
            CarryOut  <= 1'b0;
            Zero      <= (mul_next_s[W-1:0] == {W{1'b0}});
            Illegal   <= 1'b0;
          end else begin
            state_r <= MUL;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_r   <= IDLE;
            out_valid <= 1'b0;
          end else begin
            state_r <= DONE;
          end
        end
        default: begin
          state_r   <= IDLE;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

  alu_mc_checker #(.W(W)) u_checker (
    .clk       (clk),
    .rst       (rst),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Result    (Result),
    .Result_hi (Result_hi),
    .Overflow  (Overflow),
    .CarryOut  (CarryOut),
    .Zero      (Zero),
    .Illegal   (Illegal)
  );

endmodule

// File: tb/tb_alu_mc.sv
// Scoreboard bench for alu_mc: accepted ops push reference results, a negedge monitor pops and
// compares on each output handshake; directed cases cover the corner values and timing.

module tb_alu_mc;

  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] A = '0;
  logic [DW-1:0] B = '0;
  logic [3:0]    ALUop = 4'b0000;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [DW-1:0] Result, Result_hi;
  logic          Overflow, CarryOut, Zero, Illegal;

  // second instance with the multiplier disabled
  logic          in_valid1 = 1'b0;
  logic          in_ready1;
  logic [3:0]    ALUop1 = 4'b0000;
  logic          out_valid1;
  logic [DW-1:0] Result1, Result_hi1;
  logic          Overflow1, CarryOut1, Zero1, Illegal1;

  alu_mc #(.DATA_WIDTH(DW), .MUL_ENABLE(1'b1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .A(A), .B(B), .ALUop(ALUop),
    .out_valid(out_valid), .out_ready(out_ready), .Result(Result), .Result_hi(Result_hi),
    .Overflow(Overflow), .CarryOut(CarryOut), .Zero(Zero), .Illegal(Illegal));

  alu_mc #(.DATA_WIDTH(DW), .MUL_ENABLE(1'b0)) dut_nomul (
    .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1), .A(A), .B(B),
    .ALUop(ALUop1), .out_valid(out_valid1), .out_ready(1'b1), .Result(Result1),
    .Result_hi(Result_hi1), .Overflow(Overflow1), .CarryOut(CarryOut1), .Zero(Zero1),
    .Illegal(Illegal1));

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] lo;
    logic [31:0] hi;
    logic        ovf;
    logic        cout;
    logic        zero;
    logic        ill;
    int          acc;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_pass = 0;
  int   n_total = 0;
  bit   rnd_mode = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_total++;
    if (act !== expv) $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, expv, cyc);
    else n_pass++;
  endtask

  function automatic exp_t model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    longint unsigned ua = a, ub = b, t;
    longint sa = $signed(a), sb2 = $signed(b), s;
    int sh = int'(b[4:0]);
    e.lo = '0; e.hi = '0; e.ovf = 1'b0; e.cout = 1'b0; e.ill = 1'b0; e.lat = 1; e.acc = 0;
    case (op)
      4'd0:  e.lo = a & b;
      4'd1:  e.lo = a | b;
      4'd3:  e.lo = a ^ b;
      4'd4:  e.lo = ~(a | b);
      4'd2: begin
        t = ua + ub; e.lo = t[31:0]; e.cout = t[32];
        s = sa + sb2; e.ovf = (s != longint'($signed(e.lo)));
      end
      4'd6: begin
        e.lo = a - b; e.cout = (a >= b);
        s = sa - sb2; e.ovf = (s != longint'($signed(e.lo)));
      end
      4'd7:  e.lo = (sa < sb2) ? 32'd1 : 32'd0;
      4'd5:  e.lo = (ua < ub) ? 32'd1 : 32'd0;
      4'd8:  e.lo = a << sh;
      4'd9:  e.lo = a >> sh;
      4'd10: begin s = sa >>> sh; e.lo = s[31:0]; end
      4'd12: begin t = ua * ub; e.lo = t[31:0]; e.hi = t[63:32]; e.lat = DW + 1; end
      default: e.ill = 1'b1;
    endcase
    e.zero = (e.lo == 32'd0);
    return e;
  endfunction

  // Monitor: protocol timing, result comparison, stall stability, and scoreboard push on acceptance.
  logic        hold = 1'b0;
  logic [69:0] held;
  always @(negedge clk) begin
    exp_t e;
    bit   vis;
    if (rst) begin
      sb.delete();
      hold = 1'b0;
    end else begin
      vis = (sb.size() > 0) && (cyc >= sb[0].acc + sb[0].lat);
      chk("out_valid", out_valid, vis);
      chk("in_ready", in_ready, (sb.size() == 0) || (vis && out_ready));
      if (hold) chk("hold", {Result, Result_hi, Overflow, CarryOut, Zero, Illegal}, held);
      hold = 1'b0;
      if (vis && out_valid) begin
        chk("Result", Result, sb[0].lo);
        chk("Result_hi", Result_hi, sb[0].hi);
        chk("flags", {Overflow, CarryOut, Zero, Illegal},
            {sb[0].ovf, sb[0].cout, sb[0].zero, sb[0].ill});
        if (out_ready) void'(sb.pop_front());
        else begin
          hold = 1'b1;
          held = {Result, Result_hi, Overflow, CarryOut, Zero, Illegal};
        end
      end
      if (in_valid && in_ready) begin
        e = model(ALUop, A, B);
        e.acc = cyc;
        sb.push_back(e);
      end
    end
  end

  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    int   n = 0;
    logic acc;
    in_valid = 1'b1; ALUop = op; A = a; B = b;
    do begin
      if (rnd_mode) out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk); acc = in_ready;
      @(posedge clk); #1; n++;
    end while (!acc && n < 200);
    in_valid = 1'b0;
    if (!acc) begin
      n_total++;
      $display("FAIL issue_timeout: op %0h not accepted in 200 cycles", op);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      if (rnd_mode) out_ready = ($urandom_range(0, 3) != 0);
      @(posedge clk); #1;
    end
  endtask

  task automatic expect_out(input string nm, input logic [31:0] r, input logic ov, input logic co);
    @(negedge clk);
    chk({nm, "_valid"}, out_valid, 1'b1);
    chk(nm, Result, r);
    chk({nm, "_ovf_cout"}, {Overflow, CarryOut}, {ov, co});
    chk({nm, "_zero"}, Zero, (r == 32'd0));
    @(posedge clk); #1;
  endtask

  function automatic logic [31:0] rnd_operand();
    case ($urandom_range(0, 5))
      0: return 32'h0000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  logic [3:0] legal_ops [12] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7,
                                 4'd8, 4'd9, 4'd10, 4'd12};
  logic [3:0] bad_ops [4] = '{4'd11, 4'd13, 4'd14, 4'd15};

  initial begin
    int busy, lat, ones, cnt;
    bit seen;
    logic [3:0] op;

    // reset held for two cycles
    rst = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_outputs", {Result, Result_hi, Overflow, CarryOut, Zero, Illegal}, 70'd0);
    @(posedge clk); #1;

    issue(4'd2, 32'h7FFF_FFFF, 32'h0000_0001); expect_out("add_ovf", 32'h8000_0000, 1'b1, 1'b0);
    issue(4'd2, 32'hFFFF_FFFF, 32'h0000_0001); expect_out("add_carry", 32'h0, 1'b0, 1'b1);
    issue(4'd6, 32'd3, 32'd5);                 expect_out("sub", 32'hFFFF_FFFE, 1'b0, 1'b0);
    issue(4'd7, 32'h8000_0000, 32'd1);         expect_out("slt", 32'd1, 1'b0, 1'b0);
    issue(4'd5, 32'h8000_0000, 32'd1);         expect_out("sltu", 32'd0, 1'b0, 1'b0);
    issue(4'd10, 32'hF000_0000, 32'd24);       expect_out("sra", 32'hFFFF_FFF0, 1'b0, 1'b0);
    issue(4'd8, 32'd1, 32'h21);                expect_out("sll_mask", 32'd2, 1'b0, 1'b0);
    issue(4'd15, 32'h1234_5678, 32'h1);
    @(negedge clk);
    chk("illegal_flag", Illegal, 1'b1);
    chk("illegal_result", Result, 32'd0);
    @(posedge clk); #1;

    // MUL timing, with ignored in_valid pulses while busy
    issue(4'd12, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    busy = 0; lat = 0; seen = 1'b0;
    for (int i = 1; i <= 40 && !seen; i++) begin
      in_valid = (i < 20) ? i[0] : 1'b0;
      ALUop = 4'd2;
      @(negedge clk);
      if (out_valid) begin seen = 1'b1; lat = i; end
      else if (!in_ready) busy++;
      if (!seen) begin @(posedge clk); #1; end
    end
    in_valid = 1'b0;
    chk("mul_latency", lat, 33);
    chk("mul_busy_cycles", busy, 32);
    chk("mul_hi", Result_hi, 32'hFFFF_FFFE);
    chk("mul_lo", Result, 32'h0000_0001);
    @(posedge clk); #1;

    // stall: result held 5 cycles, then 4 back-to-back ADDs
    out_ready = 1'b0;
    issue(4'd2, 32'd100, 32'd23);
    idle(5);
    out_ready = 1'b1;
    cnt = 0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; ALUop = 4'd2; A = 32'd10 * i; B = 32'd1;
      @(negedge clk);
      chk("b2b_ready", in_ready, 1'b1);
      if (i > 0 && out_valid) cnt++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    @(negedge clk);
    if (out_valid) cnt++;
    chk("b2b_valid_count", cnt, 4);
    @(posedge clk); #1;

    // reset during MUL cycle 10
    issue(4'd12, $urandom, $urandom);
    repeat (9) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    ones = 0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid) ones++;
    end
    chk("mul_abort_no_valid", ones, 0);
    chk("mul_abort_ready", in_ready, 1'b1);
    @(posedge clk); #1;

    // MUL opcode on the instance with the multiplier disabled
    in_valid1 = 1'b1; ALUop1 = 4'b1100; A = 32'd7; B = 32'd9;
    @(negedge clk);
    chk("nomul_ready", in_ready1, 1'b1);
    @(posedge clk); #1 in_valid1 = 1'b0;
    @(negedge clk);
    chk("nomul_valid", out_valid1, 1'b1);
    chk("nomul_illegal", Illegal1, 1'b1);
    chk("nomul_result", {Result1, Result_hi1}, 64'd0);
    chk("nomul_flags", {Overflow1, CarryOut1, Zero1}, 3'b001);
    @(posedge clk); #1;

    // randomized traffic with random backpressure
    rnd_mode = 1'b1;
    for (int k = 0; k < 300; k++) begin
      if ($urandom_range(0, 15) == 0) op = bad_ops[$urandom_range(0, 3)];
      else op = legal_ops[$urandom_range(0, 11)];
      issue(op, rnd_operand(), rnd_operand());
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end
    rnd_mode = 1'b0;
    out_ready = 1'b1;
    cnt = 0;
    while (sb.size() != 0 && cnt < 100) begin
      @(posedge clk); #1; cnt++;
    end
    if (sb.size() != 0) begin
      n_total++;
      $display("FAIL drain_timeout: %0d results never delivered", sb.size());
    end
    idle(3);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("%0d/%0d checks passed", n_pass, n_total + 1);
    $fatal(1);
  end

endmodule
